filtered_state_decoder: RTL and testbench

//  Registered, glitch-filtered successor to the combinational player-input decoder.
//  - Synchronises an IN_W-bit input state code and accepts a new code only after it
//    has been stable for STABLE_CYCLES clocks.
//  - Decodes the accepted code to a one-hot level vector plus a one-cycle action pulse.
//  - Sits between the player controller inputs and the fighter FSM.
//  - A freeze input blocks new actions, for example during hit-stun.

---
 rtl/filtered_state_decoder.sv | 100 ++++++++++
 tb/tb_filtered_state_decoder.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/filtered_state_decoder.sv
// Glitch-filtered player-input decoder: synchronises a raw state code, accepts it once stable,
// and presents the accepted code as a one-hot level plus a one-cycle action pulse.
module filtered_state_decoder #(
  parameter int IN_W          = 2,
  parameter int STABLE_CYCLES = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [IN_W-1:0]          in_state,
  input  logic                     freeze,
  output logic [IN_W-1:0]          state_code,
  output logic [(2**IN_W)-2:0]     out_state,
  output logic [(2**IN_W)-2:0]     out_pulse
);

  localparam int OUT_W = (2**IN_W) - 1;
  localparam int CNT_W = $clog2(STABLE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STABLE_CYCLES - 1);

  // Code k maps to bit k-1; code 0 (idle) maps to all-zero.
  function automatic logic [OUT_W-1:0] onehot(input logic [IN_W-1:0] code);
    logic [OUT_W-1:0] r;
    r = '0;
    for (int k = 1; k <= OUT_W; k++) begin
      r[k-1] = (code == IN_W'(k));
    end
    return r;
  endfunction

  logic [IN_W-1:0]  sync1_q, sync1_d;
  logic [IN_W-1:0]  sync2_q, sync2_d;
  logic [IN_W-1:0]  cand_q, cand_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [IN_W-1:0]  state_code_q, state_code_d;
  logic [OUT_W-1:0] out_state_q, out_state_d;
  logic [OUT_W-1:0] out_pulse_q, out_pulse_d;
  logic             stable_s;
  logic             accept_s;

  // Next-state: synchroniser, stability filter and acceptance.
  always_comb begin
    sync1_d      = in_state;
    sync2_d      = sync1_q;
    cand_d       = cand_q;
    cnt_d        = cnt_q;
    state_code_d = state_code_q;
    out_state_d  = out_state_q;
    out_pulse_d  = '0;

    stable_s = (sync2_q == cand_q);
    accept_s = stable_s && (cnt_q == CNT_MAX) && !freeze && (cand_q != state_code_q);

    if (!stable_s) begin
      cand_d = sync2_q;
      cnt_d  = '0;
    end else if (freeze) begin
      // Frozen: keep the count at zero so release needs a full stability window again.
      cnt_d = '0;
    end else if (cnt_q < CNT_MAX) begin
      cnt_d = cnt_q + CNT_W'(1);
    end else begin
      cnt_d = cnt_q;
    end

    if (accept_s) begin
      state_code_d = cand_q;
      out_state_d  = onehot(cand_q);
      out_pulse_d  = onehot(cand_q);
    end else begin
      state_code_d = state_code_q;
      out_state_d  = out_state_q;
    end
  end

  // State registers with asynchronous clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q      <= '0;
      sync2_q      <= '0;
      cand_q       <= '0;
      cnt_q        <= '0;
      state_code_q <= '0;
      out_state_q  <= '0;
      out_pulse_q  <= '0;
    end else begin
      sync1_q      <= sync1_d;
      sync2_q      <= sync2_d;
      cand_q       <= cand_d;
      cnt_q        <= cnt_d;
      state_code_q <= state_code_d;
      out_state_q  <= out_state_d;
      out_pulse_q  <= out_pulse_d;
    end
  end

  assign state_code = state_code_q;
  assign out_state  = out_state_q;
  assign out_pulse  = out_pulse_q;

endmodule

// File: tb/tb_filtered_state_decoder.sv
// Bench for filtered_state_decoder: directed scenarios plus random stimulus against a
// sample-history window model, on a default instance and an IN_W=3 / STABLE_CYCLES=1 instance.
module tb_filtered_state_decoder;

  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] in_a;
  logic       frz_a;
  logic [2:0] in_b;
  logic       frz_b;
  logic [1:0] a_code;
  logic [2:0] a_state, a_pulse;
  logic [2:0] b_code;
  logic [6:0] b_state, b_pulse;

  int checks = 0;
  int failures = 0;

  // History per instance: index 0 = input/freeze seen at the most recent edge.
  int h[2][8];
  int f[2][8];
  int ms[2];
  int mp[2];

  filtered_state_decoder #(.IN_W(2), .STABLE_CYCLES(4)) dut_a (
    .clk(clk), .rst(rst), .in_state(in_a), .freeze(frz_a),
    .state_code(a_code), .out_state(a_state), .out_pulse(a_pulse));

  filtered_state_decoder #(.IN_W(3), .STABLE_CYCLES(1)) dut_b (
    .clk(clk), .rst(rst), .in_state(in_b), .freeze(frz_b),
    .state_code(b_code), .out_state(b_state), .out_pulse(b_pulse));

  always #5 clk = ~clk;

  function automatic int oh(int c);
    return (c == 0) ? 0 : (1 << (c - 1));
  endfunction

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reset looks like a history of idle codes with the count held at zero.
  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      for (int i = 0; i < 8; i++) begin
        h[d][i] = 0;
        f[d][i] = 1;
      end
      ms[d] = 0;
      mp[d] = 0;
    end
  endtask

  // Accept when the synchronised code was unchanged and freeze low over the last s edges.
  task automatic model_step(int d, int code, int frz, int s);
    bit ok;
    for (int i = 7; i > 0; i--) begin
      h[d][i] = h[d][i-1];
      f[d][i] = f[d][i-1];
    end
    h[d][0] = code;
    f[d][0] = frz;
    ok = 1'b1;
    for (int j = 0; j < s; j++) begin
      if (h[d][j+2] != h[d][j+3] || f[d][j] != 0) ok = 1'b0;
    end
    mp[d] = 0;
    if (ok && h[d][2] != ms[d]) begin
      ms[d] = h[d][2];
      mp[d] = oh(ms[d]);
    end
  endtask

  task automatic compare_all();
    chk("a_code", a_code, ms[0]);
    chk("a_state", a_state, oh(ms[0]));
    chk("a_pulse", a_pulse, mp[0]);
    chk("b_code", b_code, ms[1]);
    chk("b_state", b_state, oh(ms[1]));
    chk("b_pulse", b_pulse, mp[1]);
    chk("a_onehot0", 32'($onehot0(a_state)), 32'd1);
    chk("b_onehot0", 32'($onehot0(b_state)), 32'd1);
    chk("a_pulse_inv", 32'((a_pulse == 3'd0) || (a_pulse == a_state)), 32'd1);
    chk("b_pulse_inv", 32'((b_pulse == 7'd0) || (b_pulse == b_state)), 32'd1);
  endtask

  task automatic cyc();
    @(posedge clk);
    if (rst) begin
      model_reset();
    end else begin
      model_step(0, in_a, frz_a, 4);
      model_step(1, in_b, frz_b, 1);
    end
    #1;
    compare_all();
  endtask

  initial begin
    rst = 1'b1; in_a = 2'd0; frz_a = 1'b0; in_b = 3'd0; frz_b = 1'b0;
    model_reset();
    #2;
    chk("rst_a_state", a_state, 32'd0);
    chk("rst_b_state", b_state, 32'd0);
    cyc(); cyc();
    rst = 1'b0;

    // 0 -> 1 on the default instance, 0 -> 5 on the fast instance.
    in_a = 2'd1; in_b = 3'd5;
    for (int i = 1; i <= 8; i++) begin
      cyc();
      chk("t2_state", a_state, (i >= 7) ? 32'd1 : 32'd0);
      chk("t2_pulse", a_pulse, (i == 7) ? 32'd1 : 32'd0);
      chk("t2_code", a_code, (i >= 7) ? 32'd1 : 32'd0);
      chk("t6_state", b_state, (i >= 4) ? 32'(7'b0010000) : 32'd0);
    end

    // Code 2 interrupted by a 2-cycle glitch to 3.
    in_a = 2'd2;
    cyc(); cyc();
    in_a = 2'd3;
    cyc(); cyc();
    in_a = 2'd2;
    for (int i = 1; i <= 8; i++) begin
      cyc();
      chk("t3_state", a_state, (i >= 7) ? 32'd2 : 32'd1);
      chk("t3_pulse", a_pulse, (i == 7) ? 32'd2 : 32'd0);
    end

    // Accept 3, then return to idle with no pulse.
    in_a = 2'd3;
    for (int i = 1; i <= 8; i++) cyc();
    chk("t4_pre", a_state, 32'd4);
    in_a = 2'd0;
    for (int i = 1; i <= 8; i++) begin
      cyc();
      chk("t4_state", a_state, (i >= 7) ? 32'd0 : 32'd4);
      chk("t4_pulse", a_pulse, 32'd0);
    end

    // Freeze holds the accepted code; release needs four more edges.
    in_a = 2'd1;
    for (int i = 1; i <= 8; i++) cyc();
    frz_a = 1'b1; in_a = 2'd2;
    for (int i = 1; i <= 20; i++) begin
      cyc();
      chk("t5_hold", a_state, 32'd1);
      chk("t5_nopulse", a_pulse, 32'd0);
    end
    frz_a = 1'b0;
    for (int i = 1; i <= 5; i++) begin
      cyc();
      chk("t5_state", a_state, (i >= 4) ? 32'd2 : 32'd1);
      chk("t5_pulse", a_pulse, (i == 4) ? 32'd2 : 32'd0);
    end

    // Asynchronous reset mid-run with code 3 held.
    in_a = 2'd3;
    for (int i = 1; i <= 8; i++) cyc();
    #3;
    rst = 1'b1;
    model_reset();
    #1;
    chk("t1_state", a_state, 32'd0);
    chk("t1_code", a_code, 32'd0);
    chk("t1_pulse", a_pulse, 32'd0);
    chk("t1_b_state", b_state, 32'd0);
    cyc();
    rst = 1'b0;
    for (int i = 1; i <= 8; i++) begin
      cyc();
      chk("t1_rel_state", a_state, (i >= 7) ? 32'd4 : 32'd0);
      chk("t1_rel_pulse", a_pulse, (i == 7) ? 32'd4 : 32'd0);
    end

    // Random codes with occasional glitches and freeze toggles.
    for (int n = 0; n < 600; n++) begin
      if ($urandom_range(7) == 0) in_a = 2'($urandom_range(3));
      if ($urandom_range(5) == 0) in_b = 3'($urandom_range(7));
      if ($urandom_range(15) == 0) frz_a = ~frz_a;
      if ($urandom_range(15) == 0) frz_b = ~frz_b;
      cyc();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
